// File: rtl/tank_io_pkg.sv
// Shared constants for the tank controller I/O path: button bit layout,
// debounce default and the MMIO addresses the conditioned buttons appear at.
package tank_io_pkg;

  localparam int NUM_BTN = 8;

  // Bit positions inside every 8-bit button bus (low nibble = controller 1).
  localparam int BTN_C1_UP    = 0;
  localparam int BTN_C1_LEFT  = 1;
  localparam int BTN_C1_RIGHT = 2;
  localparam int BTN_C1_DOWN  = 3;
  localparam int BTN_C2_UP    = 4;
  localparam int BTN_C2_LEFT  = 5;
  localparam int BTN_C2_RIGHT = 6;
  localparam int BTN_C2_DOWN  = 7;

  // 2.5 ms at 100 MHz.
  localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

  // MMIO words: debounced levels, then sticky pressed flags.
  localparam logic [31:0] MMIO_BTN_LEVEL_ADDR   = 32'hFFFF0000;
  localparam logic [31:0] MMIO_BTN_PRESSED_ADDR = 32'hFFFF0004;

endpackage

// File: rtl/jd_input_conditioner_if.sv
// Bus between the raw Pmod JD pins / MMIO read logic and the conditioner.
// There is no valid/ready handshake on this bus: JD is a free-running
// asynchronous level, clr_pressed is a one-cycle pulse that is honoured in
// the cycle it is high, and all three outputs are registered levels that
// the consumer may sample on any clk edge.
interface jd_input_conditioner_if;
  import tank_io_pkg::*;

  logic [10:1]        JD;
  logic [NUM_BTN-1:0] clr_pressed;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press_pulse;
  logic [NUM_BTN-1:0] btn_pressed;

  // Pins / MMIO side.
  modport master (
    output JD,
    output clr_pressed,
    input  btn_level,
    input  btn_press_pulse,
    input  btn_pressed
  );

  // Conditioner side.
  modport slave (
    input  JD,
    input  clr_pressed,
    output btn_level,
    output btn_press_pulse,
    output btn_pressed
  );

endinterface

// File: rtl/jd_input_conditioner_btn_debounce.sv
// One button line: synchroniser chain, hold-time debounce counter, accepted
// (stable) level and a one-cycle pulse on an accepted 0->1 change.
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   stable_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   pulse_q;

  // Plain flop chain, nothing between stages, to resolve metastability.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Accept a new value only after it has differed from stable for
  // DEBOUNCE_CYCLES consecutive cycles; any return to stable restarts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (sync == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        stable_q <= sync;
        cnt_q    <= '0;
        // Accepting a 1 means stable was 0, so this is exactly a rise.
        pulse_q  <= sync;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level       = stable_q;
  assign press_pulse = pulse_q;

endmodule

// File: rtl/jd_input_conditioner.sv
// Conditions both joystick controllers' JD pins into clean, debounced
// button levels, press pulses and sticky pressed flags for MMIO readout.
module jd_input_conditioner
  import tank_io_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  jd_input_conditioner_if.slave  bus
);

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] pulse;
  logic [NUM_BTN-1:0] pressed_q;
  logic               unused_pins;

  // Pin map into MMIO bit order; controller 2 down sits on JD[7].
  assign raw[BTN_C1_UP]    = bus.JD[1];
  assign raw[BTN_C1_LEFT]  = bus.JD[2];
  assign raw[BTN_C1_RIGHT] = bus.JD[3];
  assign raw[BTN_C1_DOWN]  = bus.JD[4];
  assign raw[BTN_C2_UP]    = bus.JD[8];
  assign raw[BTN_C2_LEFT]  = bus.JD[9];
  assign raw[BTN_C2_RIGHT] = bus.JD[10];
  assign raw[BTN_C2_DOWN]  = bus.JD[7];

  // JD[5] and JD[6] are not wired to any button.
  assign unused_pins = ^{bus.JD[6], bus.JD[5]};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .din        (raw[i]),
      .level      (level[i]),
      .press_pulse(pulse[i])
    );
  end

  // Sticky flags: a press sets, a clear pulse clears, set wins a tie so a
  // press landing in the same cycle as a read-clear is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pressed_q <= '0;
    else       pressed_q <= pulse | (pressed_q & ~bus.clr_pressed);
  end

  assign bus.btn_level       = level;
  assign bus.btn_press_pulse = pulse;
  assign bus.btn_pressed     = pressed_q;

endmodule

// File: tb/tb_jd_input_conditioner.sv
// Directed bench for jd_input_conditioner with DEBOUNCE_CYCLES=4,
// SYNC_STAGES=2. The driver pushes hand-computed expectations tagged with
// the clk edge count after which they must hold; the monitor pops and
// compares them shortly after each rising edge.
module tb_jd_input_conditioner;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  // {edge count[31:0], level[7:0], pulse[7:0], pressed[7:0]}
  logic [55:0] exp_q[$];
  string       name_q[$];

  jd_input_conditioner_if bus();

  jd_input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic expect_at(input int at, input logic [7:0] lvl,
                           input logic [7:0] pls, input logic [7:0] prs,
                           input string nm);
    exp_q.push_back({32'(at), lvl, pls, prs});
    name_q.push_back(nm);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [55:0] e;
  string       nm;
  always begin
    @(posedge clk);
    #1;
    while (exp_q.size() > 0 && int'(exp_q[0][55:24]) <= cyc) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      total++;
      if (int'(e[55:24]) != cyc) begin
        $display("FAIL %s: check for edge %0d missed (now edge %0d)",
                 nm, int'(e[55:24]), cyc);
      end else if (bus.btn_level === e[23:16] && bus.btn_press_pulse === e[15:8] &&
                   bus.btn_pressed === e[7:0]) begin
        passed++;
      end else begin
        $display("FAIL %s @edge %0d: got level=%h pulse=%h pressed=%h, expected level=%h pulse=%h pressed=%h",
                 nm, cyc, bus.btn_level, bus.btn_press_pulse, bus.btn_pressed,
                 e[23:16], e[15:8], e[7:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  int c;
  initial begin
    reset           = 1'b1;
    bus.JD          = '1;
    bus.clr_pressed = '0;

    // Reset with all pins pressed, then release: every bit is a new press.
    repeat (3) @(negedge clk);
    c = cyc;
    expect_at(c + 1, 8'h00, 8'h00, 8'h00, "in_reset");
    @(negedge clk);
    c = cyc;
    reset = 1'b0;
    expect_at(c + 5, 8'h00, 8'h00, 8'h00, "all_pre_accept");
    expect_at(c + 6, 8'hFF, 8'hFF, 8'h00, "all_level");
    expect_at(c + 7, 8'hFF, 8'h00, 8'hFF, "all_pressed");
    wait_until(c + 7);
    bus.clr_pressed = 8'hFF;
    bus.JD          = '0;
    expect_at(c + 8,  8'hFF, 8'h00, 8'h00, "clr_all");
    expect_at(c + 12, 8'hFF, 8'h00, 8'h00, "release_hold");
    expect_at(c + 13, 8'h00, 8'h00, 8'h00, "all_release");
    wait_until(c + 8);
    bus.clr_pressed = '0;
    wait_until(c + 14);

    // c1_right glitches of 3 cycles, 5 times: never accepted.
    c = cyc;
    for (int k = 1; k <= 36; k++) expect_at(c + k, 8'h00, 8'h00, 8'h00, "glitch");
    for (int r = 0; r < 5; r++) begin
      bus.JD[3] = 1'b1;
      repeat (3) @(negedge clk);
      bus.JD[3] = 1'b0;
      repeat (3) @(negedge clk);
    end
    wait_until(c + 36);

    // c2_down (JD[7]) press and release.
    c = cyc;
    bus.JD[7] = 1'b1;
    expect_at(c + 5, 8'h00, 8'h00, 8'h00, "c2_down_early");
    expect_at(c + 6, 8'h80, 8'h80, 8'h00, "c2_down_level");
    expect_at(c + 7, 8'h80, 8'h00, 8'h80, "c2_down_pressed");
    wait_until(c + 7);
    bus.JD[7] = 1'b0;
    expect_at(c + 12, 8'h80, 8'h00, 8'h80, "c2_down_rel_hold");
    expect_at(c + 13, 8'h00, 8'h00, 8'h80, "c2_down_rel_no_pulse");
    expect_at(c + 14, 8'h00, 8'h00, 8'h80, "c2_down_rel_after");
    wait_until(c + 14);
    bus.clr_pressed = 8'h80;
    expect_at(c + 15, 8'h00, 8'h00, 8'h00, "c2_down_clr");
    wait_until(c + 15);
    bus.clr_pressed = '0;

    // c1_up: set flag, then re-press with a coincident clear.
    c = cyc;
    bus.JD[1] = 1'b1;
    expect_at(c + 6, 8'h01, 8'h01, 8'h00, "c1_up_pulse");
    expect_at(c + 7, 8'h01, 8'h00, 8'h01, "c1_up_pressed");
    wait_until(c + 7);
    bus.JD[1] = 1'b0;
    expect_at(c + 13, 8'h00, 8'h00, 8'h01, "c1_up_released");
    wait_until(c + 13);
    c = cyc;
    bus.JD[1] = 1'b1;
    expect_at(c + 6, 8'h01, 8'h01, 8'h01, "repress_pulse");
    expect_at(c + 7, 8'h01, 8'h00, 8'h01, "set_wins");
    expect_at(c + 9, 8'h01, 8'h00, 8'h00, "clr_alone");
    wait_until(c + 6);
    bus.clr_pressed = 8'h01;
    wait_until(c + 7);
    bus.clr_pressed = '0;
    wait_until(c + 8);
    bus.clr_pressed = 8'h01;
    wait_until(c + 9);
    bus.clr_pressed = '0;
    bus.JD[1] = 1'b0;
    expect_at(c + 15, 8'h00, 8'h00, 8'h00, "c1_up_rel2");
    wait_until(c + 15);

    // JD[1] and JD[10] together, partial clears.
    c = cyc;
    bus.JD[1]  = 1'b1;
    bus.JD[10] = 1'b1;
    expect_at(c + 6, 8'h41, 8'h41, 8'h00, "dual_pulse");
    expect_at(c + 7, 8'h41, 8'h00, 8'h41, "dual_pressed");
    wait_until(c + 7);
    bus.clr_pressed = 8'h40;
    expect_at(c + 8, 8'h41, 8'h00, 8'h01, "clr_c2_right");
    wait_until(c + 8);
    bus.clr_pressed = 8'h02;
    expect_at(c + 9, 8'h41, 8'h00, 8'h01, "clr_unset");
    wait_until(c + 9);
    bus.clr_pressed = '0;
    bus.JD[1]  = 1'b0;
    bus.JD[10] = 1'b0;
    expect_at(c + 15, 8'h00, 8'h00, 8'h01, "dual_release");
    wait_until(c + 15);
    bus.clr_pressed = 8'h01;
    expect_at(c + 16, 8'h00, 8'h00, 8'h00, "dual_clr");
    wait_until(c + 16);
    bus.clr_pressed = '0;

    // Reset in the middle of a c1_left debounce while c2_up is held.
    c = cyc;
    bus.JD[8] = 1'b1;
    expect_at(c + 6, 8'h10, 8'h10, 8'h00, "c2_up_pulse");
    expect_at(c + 7, 8'h10, 8'h00, 8'h10, "c2_up_pressed");
    wait_until(c + 7);
    c = cyc;
    bus.JD[2] = 1'b1;
    wait_until(c + 4);
    reset = 1'b1;
    expect_at(c + 5, 8'h00, 8'h00, 8'h00, "mid_reset");
    wait_until(c + 5);
    reset = 1'b0;
    expect_at(c + 10, 8'h00, 8'h00, 8'h00, "no_partial");
    expect_at(c + 11, 8'h12, 8'h12, 8'h00, "restart_level");
    expect_at(c + 12, 8'h12, 8'h00, 8'h12, "restart_pressed");
    wait_until(c + 13);

    // Drain, bounded; anything left over was never checked.
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(negedge clk);
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      total++;
      $display("FAIL %s: expectation for edge %0d never reached", nm, int'(e[55:24]));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
